subservient_sram_arbiter: RTL and testbench
===========================================

// Module: subservient_sram_arbiter
// PURPOSE
//  Shares the 1 kB dual-port SRAM macro (write port 0, read port 1, 256x32, per-byte wmask)
//  between the SERV core's byte-wide SRAM interface and a 32-bit Wishbone host (loader/mgmt).
//  The core has no stall input, so it always wins; the host is granted only idle port cycles.
//  Also does the byte-lane steering (byte->word mask/mirror, word->byte select).
// PARAMETERS
//  AW       10   byte address width on both requesters (2^AW bytes)
//  TIMEOUT  255  host wait-cycle limit, used only with SRAM_ARB_TIMEOUT_EN
// PORTS
//  i_clk         in   1   clock
//  i_rst         in   1   asynchronous reset, active high
//  i_core_waddr  in   AW  core byte write address
//  i_core_wdata  in   8   core write byte
//  i_core_wen    in   1   core write strobe (single cycle)
//  i_core_raddr  in   AW  core byte read address
//  i_core_ren    in   1   core read strobe (single cycle)
//  o_core_rdata  out  8   core read byte, valid cycle after i_core_ren
//  i_wb_adr      in   AW  host byte address, [1:0] ignored
//  i_wb_dat      in   32  host write data
//  i_wb_sel      in   4   host byte enables
//  i_wb_we       in   1   host write
//  i_wb_stb      in   1   host request, held until ack/err
//  o_wb_rdt      out  32  host read data, valid with o_wb_ack
//  o_wb_ack      out  1   host ack, 1-cycle pulse
//  o_wb_err      out  1   host error pulse (timeout), 0 without SRAM_ARB_TIMEOUT_EN
//  o_csb0        out  1   SRAM write chip select, active low
//  o_wmask0      out  4   SRAM write byte mask
//  o_waddr0      out  AW-2 SRAM write word address
//  o_din0        out  32  SRAM write data
//  o_csb1        out  1   SRAM read chip select, active low
//  o_addr1       out  AW-2 SRAM read word address
//  i_dout1       in   32  SRAM read data, valid cycle after o_csb1 low
// BEHAVIOUR
//  Reset: o_csb0=o_csb1=1, o_wb_ack=o_wb_err=0, o_wb_rdt=0, lane reg=0, FSM=IDLE, wait cnt=0.
//  Core write (comb.): wen -> csb0=0, wmask0=1<<waddr[1:0], waddr0=waddr[AW-1:2], din0={4{wdata}}.
//  Core read (comb.): ren -> csb1=0, addr1=raddr[AW-1:2]; raddr[1:0] registered on ren;
//   o_core_rdata=i_dout1[lane*8+:8] using registered lane (1-cycle latency, matches macro).
//  Ports arbitrated independently; host write needs port 0 free, host read needs port 1 free.
//  FSM IDLE: stb&we&!core_wen -> drive port0 (wmask0=sel, din0=dat, waddr0=adr[AW-1:2]) -> WACK.
//            stb&!we&!core_ren -> drive port1 (addr1=adr[AW-1:2]) -> RWAIT.
//            stb with port busy -> stay IDLE, wait cnt++. No stb -> wait cnt=0.
//  WACK:  o_wb_ack=1 one cycle -> IDLE. sel=0 write: csb0 stays 1, still acked.
//  RWAIT: o_wb_rdt<=i_dout1 -> RACK.  RACK: o_wb_ack=1 one cycle -> IDLE.
//  Latency, idle port: write ack cycle N+1, read ack cycle N+2 (N = grant cycle).
//  Core accesses during RWAIT/RACK/WACK proceed unaffected (host holds no port past grant).
//  Host never masks core: grant decision uses same-cycle core strobes; simultaneous -> core.
//  Host request dropped before ack: FSM completes access, ack still pulses (master ignores).
//  Async reset mid-access: outputs return to reset values immediately; no ack issued.
// CONFIGURATION
//  SRAM_ARB_TIMEOUT_EN defined: wait cnt reaching TIMEOUT in IDLE with stb pending -> no SRAM
//   access, o_wb_err=1 one cycle, cnt cleared, FSM IDLE. Counter width $clog2(TIMEOUT+1).
//  Undefined: no counter, host waits indefinitely, o_wb_err tied 0.
// TESTING
//  Core wen waddr=0x006 wdata=0x5A -> same cycle csb0=0 wmask0=4'b0100 waddr0=1 din0=0x5A5A5A5A.
//  Core ren raddr=0x007, next cycle i_dout1=0x11223344 -> o_core_rdata=0x11.
//  Host write adr=0x010 dat=0xDEADBEEF sel=4'hF, core idle -> csb0=0 waddr0=4 1 cycle, ack next.
//  Host read adr=0x010 while core ren high 5 cycles -> csb1 never host's until ren low; then
//   addr1=4, ack 2 cycles later with o_wb_rdt=i_dout1 (0xDEADBEEF from model).
//  Core wen and host write same cycle -> core byte written first, host granted next free cycle.
//  Assert i_rst during RWAIT -> csb1=1, no ack; after release a new read completes normally.
//  (TIMEOUT_EN, TIMEOUT=4) host read, core ren held 10 cycles -> o_wb_err pulse, no ack, no csb1.

Source files
------------

// File: rtl/subservient_sram_arbiter.sv
// Shares a 256x32 dual-port SRAM macro between the SERV byte-wide port (always wins) and a
// Wishbone host. Optional host wait timeout is enabled with `define SRAM_ARB_TIMEOUT_EN.
module subservient_sram_arbiter #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_core_waddr,
  input  logic [7:0]    i_core_wdata,
  input  logic          i_core_wen,
  input  logic [AW-1:0] i_core_raddr,
  input  logic          i_core_ren,
  output logic [7:0]    o_core_rdata,
  input  logic [AW-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic          o_csb0,
  output logic [3:0]    o_wmask0,
  output logic [AW-3:0] o_waddr0,
  output logic [31:0]   o_din0,
  output logic          o_csb1,
  output logic [AW-3:0] o_addr1,
  input  logic [31:0]   i_dout1
);

  typedef enum logic [1:0] {IDLE, WACK, RWAIT, RACK} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdt_q, rdt_d;

  logic core_wen, core_ren;
  logic host_pend, host_wgrant, host_rgrant, timeout;
  logic unused_bits;

  // Strobes are gated by reset so the macro sees no access while reset is asserted.
  assign core_wen  = i_core_wen & ~i_rst;
  assign core_ren  = i_core_ren & ~i_rst;
  assign host_pend = (state_q == IDLE) & i_wb_stb & ~i_rst;

  assign host_wgrant = host_pend &  i_wb_we & ~core_wen & ~timeout;
  assign host_rgrant = host_pend & ~i_wb_we & ~core_ren & ~timeout;

  assign unused_bits = ^{i_wb_adr[1:0], 32'(TIMEOUT)};

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = host_pend & (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (host_pend && !timeout && !host_wgrant && !host_rgrant) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      rdt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rdt_q   <= rdt_d;
    end
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (host_wgrant)      state_d = WACK;
        else if (host_rgrant) state_d = RWAIT;
      end
      WACK:  state_d = IDLE;
      RWAIT: state_d = RACK;
      RACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_d = core_ren ? i_core_raddr[1:0] : lane_q;
    rdt_d  = (state_q == RWAIT) ? i_dout1 : rdt_q;
  end

  always_comb begin
    o_csb0   = 1'b1;
    o_wmask0 = 4'd0;
    o_waddr0 = '0;
    o_din0   = 32'd0;
    o_csb1   = 1'b1;
    o_addr1  = '0;

    if (core_wen) begin
      o_csb0   = 1'b0;
      o_wmask0 = 4'b0001 << i_core_waddr[1:0];
      o_waddr0 = i_core_waddr[AW-1:2];
      o_din0   = {4{i_core_wdata}};
    end else if (host_wgrant) begin
      // An all-zero byte select still completes the cycle but never touches the macro.
      o_csb0   = ~|i_wb_sel;
      o_wmask0 = i_wb_sel;
      o_waddr0 = i_wb_adr[AW-1:2];
      o_din0   = i_wb_dat;
    end

    if (core_ren) begin
      o_csb1  = 1'b0;
      o_addr1 = i_core_raddr[AW-1:2];
    end else if (host_rgrant) begin
      o_csb1  = 1'b0;
      o_addr1 = i_wb_adr[AW-1:2];
    end
  end

  always_comb begin
    o_wb_ack = (state_q == WACK) | (state_q == RACK);
    o_wb_err = timeout;
  end

  assign o_wb_rdt     = rdt_q;
  assign o_core_rdata = i_dout1[{lane_q, 3'b000} +: 8];

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Directed bench for subservient_sram_arbiter with a behavioural 256x32 dual-port SRAM model.
// Build with `define SRAM_ARB_TIMEOUT_EN to exercise the host timeout path (TIMEOUT=4).
module tb_subservient_sram_arbiter;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  core_waddr, core_raddr, wb_adr;
  logic [7:0]  core_wdata, core_rdata;
  logic        core_wen, core_ren;
  logic [31:0] wb_dat, wb_rdt;
  logic [3:0]  wb_sel, wmask0;
  logic        wb_we, wb_stb, wb_ack, wb_err;
  logic        csb0, csb1;
  logic [7:0]  waddr0, addr1;
  logic [31:0] din0, dout1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  subservient_sram_arbiter #(.AW(10), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_wen(core_wen),
    .i_core_raddr(core_raddr), .i_core_ren(core_ren), .o_core_rdata(core_rdata),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_csb0(csb0), .o_wmask0(wmask0), .o_waddr0(waddr0), .o_din0(din0),
    .o_csb1(csb1), .o_addr1(addr1), .i_dout1(dout1)
  );

  // SRAM macro model: masked write on port 0, registered read on port 1.
  initial begin
    mem[0] <= 32'hA0B1C2D3;
    mem[1] <= 32'h11223344;
    mem[4] <= 32'h00000000;
  end

  always @(posedge clk) begin
    if (!csb0) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask0[b]) mem[waddr0][b*8 +: 8] <= din0[b*8 +: 8];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    core_waddr = '0; core_wdata = '0; core_wen = 1'b0;
    core_raddr = '0; core_ren = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0;

    #2;
    check("rst_csb0", csb0, 1'b1);
    check("rst_csb1", csb1, 1'b1);
    check("rst_ack", wb_ack, 1'b0);
    check("rst_err", wb_err, 1'b0);
    check("rst_rdt", wb_rdt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Core byte write: lane 2 of word 1.
    core_wen = 1'b1; core_waddr = 10'h006; core_wdata = 8'h5A;
    #1;
    check("cw_csb0", csb0, 1'b0);
    check("cw_wmask0", wmask0, 4'b0100);
    check("cw_waddr0", waddr0, 8'd1);
    check("cw_din0", din0, 32'h5A5A5A5A);
    step();
    core_wen = 1'b0;
    #1;
    check("cw_idle_csb0", csb0, 1'b1);

    // Core byte reads from word 1 (now 0x115A3344).
    core_ren = 1'b1; core_raddr = 10'h007;
    #1;
    check("cr_csb1", csb1, 1'b0);
    check("cr_addr1", addr1, 8'd1);
    step();
    core_ren = 1'b0;
    #1;
    check("cr_lane3", core_rdata, 8'h11);
    core_ren = 1'b1; core_raddr = 10'h005;
    step();
    core_ren = 1'b0;
    #1;
    check("cr_lane1", core_rdata, 8'h33);
    step();

    // Host write to an idle port: granted at once, ack the following cycle.
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 10'h010; wb_dat = 32'hDEADBEEF; wb_sel = 4'hF;
    #1;
    check("hw_csb0", csb0, 1'b0);
    check("hw_waddr0", waddr0, 8'd4);
    check("hw_wmask0", wmask0, 4'hF);
    check("hw_din0", din0, 32'hDEADBEEF);
    check("hw_ack_early", wb_ack, 1'b0);
    step();
    #1;
    check("hw_ack", wb_ack, 1'b1);
    check("hw_csb0_after", csb0, 1'b1);
    wb_stb = 1'b0; wb_we = 1'b0;
    step();
    check("hw_ack_drop", wb_ack, 1'b0);

    // Host read blocked by 5 cycles of core reads, then granted.
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 10'h010;
    core_ren = 1'b1; core_raddr = 10'h000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hr_blk_csb1", csb1, 1'b0);
      check("hr_blk_addr1", addr1, 8'd0);
      check("hr_blk_ack", wb_ack, 1'b0);
      if (i > 0) check("hr_blk_core", core_rdata, 8'hD3);
      step();
    end
    core_ren = 1'b0;
    #1;
    check("hr_grant_csb1", csb1, 1'b0);
    check("hr_grant_addr1", addr1, 8'd4);
    step();
    check("hr_wait_ack", wb_ack, 1'b0);
    check("hr_wait_csb1", csb1, 1'b1);
    step();
    check("hr_ack", wb_ack, 1'b1);
    check("hr_rdt", wb_rdt, 32'hDEADBEEF);
    wb_stb = 1'b0;
    step();
    check("hr_ack_drop", wb_ack, 1'b0);

    // Core write and host write in the same cycle: core first, host next cycle.
    core_wen = 1'b1; core_waddr = 10'h011; core_wdata = 8'h77;
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 10'h010; wb_dat = 32'h01020304; wb_sel = 4'b0001;
    #1;
    check("cc_core_wmask0", wmask0, 4'b0010);
    check("cc_core_din0", din0, 32'h77777777);
    check("cc_core_waddr0", waddr0, 8'd4);
    step();
    core_wen = 1'b0;
    #1;
    check("cc_host_csb0", csb0, 1'b0);
    check("cc_host_wmask0", wmask0, 4'b0001);
    check("cc_host_din0", din0, 32'h01020304);
    check("cc_host_ack_early", wb_ack, 1'b0);
    step();
    check("cc_host_ack", wb_ack, 1'b1);
    wb_stb = 1'b0; wb_we = 1'b0;
    step();

    // Read back the merged word through the host port.
    wb_stb = 1'b1; wb_adr = 10'h012;
    step();
    step();
    check("cc_rb_ack", wb_ack, 1'b1);
    check("cc_rb_rdt", wb_rdt, 32'hDEAD7704);
    wb_stb = 1'b0;
    step();

    // Host write with no byte enables: no macro access, still acked.
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 10'h000; wb_sel = 4'h0; wb_dat = 32'hFFFFFFFF;
    #1;
    check("sel0_csb0", csb0, 1'b1);
    step();
    check("sel0_ack", wb_ack, 1'b1);
    wb_stb = 1'b0; wb_we = 1'b0;
    step();

    // Host read while the core reads for 10 cycles.
    wb_stb = 1'b1; wb_adr = 10'h010;
    core_ren = 1'b1; core_raddr = 10'h000;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("to_csb1", csb1, 1'b0);
      check("to_addr1", addr1, 8'd0);
      check("to_ack", wb_ack, 1'b0);
      check("to_err", wb_err, (TMO_EN && i == 4) ? 1'b1 : 1'b0);
      step();
      if (TMO_EN && i == 4) wb_stb = 1'b0;
    end
    core_ren = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
    #1;
    check("to_after_csb1", csb1, 1'b1);
    step();
    check("to_after_ack", wb_ack, 1'b0);
    step();
    check("to_after_ack2", wb_ack, 1'b0);
`else
    #1;
    check("nto_grant_csb1", csb1, 1'b0);
    check("nto_grant_addr1", addr1, 8'd4);
    step();
    step();
    check("nto_ack", wb_ack, 1'b1);
    check("nto_rdt", wb_rdt, 32'hDEAD7704);
    wb_stb = 1'b0;
    step();
`endif

    // Async reset while waiting for read data.
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 10'h010;
    #1;
    check("rr_grant_csb1", csb1, 1'b0);
    step();
    rst = 1'b1; wb_stb = 1'b0;
    #1;
    check("rr_csb1", csb1, 1'b1);
    check("rr_ack", wb_ack, 1'b0);
    check("rr_rdt", wb_rdt, 32'h0);
    step();
    check("rr_ack_hold", wb_ack, 1'b0);
    rst = 1'b0;
    wb_stb = 1'b1; wb_adr = 10'h000;
    #1;
    check("rr_new_csb1", csb1, 1'b0);
    check("rr_new_addr1", addr1, 8'd0);
    step();
    step();
    check("rr_new_ack", wb_ack, 1'b1);
    check("rr_new_rdt", wb_rdt, 32'hA0B1C2D3);
    wb_stb = 1'b0;
    step();
    check("rr_new_ack_drop", wb_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
